// File: rtl/fm_write_back_ctrl.sv
// Feature-map write-back controller: zeroes the output range, then streams
// conv tiles into RAM as overwrites (first pass) or two-cycle accumulates.
module fm_write_back_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int PARA_X           = 3,
  parameter int PARA_Y           = 3,
  parameter int PARA_KERNEL      = 2,
  parameter int WRITE_ADDR_WIDTH = 16,
  parameter int FM_SIZE_WIDTH    = 8,
  parameter int CH_WIDTH         = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [FM_SIZE_WIDTH-1:0]               fm_out_size,
  input  logic [CH_WIDTH-1:0]                    in_channels,
  input  logic                                   tile_valid,
  output logic                                   tile_ready,
  input  logic [PARA_Y*PARA_KERNEL*DATA_WIDTH-1:0] tile_data,
  input  logic                                   write_ready,
  output logic                                   ena_zero_w,
  output logic [WRITE_ADDR_WIDTH-1:0]            zero_start_addr,
  output logic [WRITE_ADDR_WIDTH-1:0]            zero_end_addr,
  output logic                                   ena_para_w,
  output logic                                   ena_add_write,
  output logic [WRITE_ADDR_WIDTH-1:0]            addr_para_write,
  output logic [FM_SIZE_WIDTH-1:0]               fm_size_o,
  output logic [PARA_Y*PARA_KERNEL*DATA_WIDTH-1:0] para_din,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err_sync
);

  localparam int AW = WRITE_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ZERO, WAIT_TILE, WRITE, ADD0, ADD1
  } state_t;

  state_t state, state_n;

  logic [AW-1:0]       size_ext;
  logic [AW-1:0]       tiles_x;
  logic [AW-1:0]       tiles_y;
  logic [AW-1:0]       t_calc;
  logic [AW-1:0]       t_total;
  logic [AW-1:0]       tile_idx;
  logic [CH_WIDTH-1:0] chans;
  logic [CH_WIDTH-1:0] chan_idx;
  logic                chk_pend;
  logic                accept;
  logic                write_end;
  logic                last_tile;
  logic                last_pass;
  logic                done_set;

  assign size_ext  = AW'(fm_out_size);
  assign tiles_x   = (size_ext + AW'(PARA_X - 1)) / AW'(PARA_X);
  assign tiles_y   = (size_ext + AW'(PARA_Y - 1)) / AW'(PARA_Y);
  assign t_calc    = tiles_x * tiles_y;

  assign accept    = (state == WAIT_TILE) && tile_valid;
  assign write_end = (state == WRITE) || (state == ADD1);
  assign last_tile = (tile_idx == t_total - AW'(1));
  assign last_pass = (chan_idx == chans - CH_WIDTH'(1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start) state_n = ZERO;
      ZERO: begin
        if (t_total == '0 || chans == '0) state_n = IDLE;
        else                              state_n = WAIT_TILE;
      end
      WAIT_TILE: begin
        if (tile_valid)
          state_n = (chan_idx == '0) ? WRITE : ADD0;
      end
      WRITE:     state_n = (last_tile && last_pass) ? IDLE : WAIT_TILE;
      ADD0:      state_n = ADD1;
      ADD1:      state_n = (last_tile && last_pass) ? IDLE : WAIT_TILE;
      default:   state_n = IDLE;
    endcase
  end

  assign done_set        = (state != IDLE) && (state_n == IDLE);
  assign busy            = (state != IDLE);
  assign tile_ready      = (state == WAIT_TILE);
  assign ena_zero_w      = (state == ZERO);
  assign ena_para_w      = (state == WRITE) || (state == ADD0) || (state == ADD1);
  assign ena_add_write   = (state == ADD0) || (state == ADD1);
  assign zero_start_addr = '0;
  assign zero_end_addr   = (state == ZERO)
                         ? AW'(PARA_KERNEL * PARA_Y) * t_total : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      done            <= 1'b0;
      err_sync        <= 1'b0;
      chk_pend        <= 1'b0;
      fm_size_o       <= '0;
      chans           <= '0;
      t_total         <= '0;
      tile_idx        <= '0;
      chan_idx        <= '0;
      para_din        <= '0;
      addr_para_write <= '0;
    end else begin
      state    <= state_n;
      done     <= done_set;
      chk_pend <= (state == ADD1);
      // RAM must have acknowledged the accumulate by the cycle after ADD1
      if (chk_pend && !write_ready) err_sync <= 1'b1;
      if (state == IDLE && start) begin
        fm_size_o <= fm_out_size;
        chans     <= in_channels;
        t_total   <= t_calc;
        tile_idx  <= '0;
        chan_idx  <= '0;
      end
      if (accept) begin
        para_din        <= tile_data;
        addr_para_write <= tile_idx * AW'(PARA_Y);
      end
      if (write_end) begin
        if (last_tile) begin
          tile_idx <= '0;
          chan_idx <= chan_idx + CH_WIDTH'(1);
        end else begin
          tile_idx <= tile_idx + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_write_back_ctrl.sv
// Directed bench for fm_write_back_ctrl: zero strobe, overwrite and
// accumulate passes, write_ready error, gaps, reset mid-add, empty layers.
module tb_fm_write_back_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  fm_out_size;
  logic [9:0]  in_channels;
  logic        tile_valid;
  logic        tile_ready;
  logic [95:0] tile_data;
  logic        write_ready;
  logic        ena_zero_w;
  logic [15:0] zero_start_addr;
  logic [15:0] zero_end_addr;
  logic        ena_para_w;
  logic        ena_add_write;
  logic [15:0] addr_para_write;
  logic [7:0]  fm_size_o;
  logic [95:0] para_din;
  logic        busy;
  logic        done;
  logic        err_sync;

  int errors = 0;
  int checks = 0;

  fm_write_back_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fm_out_size(fm_out_size), .in_channels(in_channels),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .write_ready(write_ready),
    .ena_zero_w(ena_zero_w), .zero_start_addr(zero_start_addr),
    .zero_end_addr(zero_end_addr), .ena_para_w(ena_para_w),
    .ena_add_write(ena_add_write), .addr_para_write(addr_para_write),
    .fm_size_o(fm_size_o), .para_din(para_din), .busy(busy),
    .done(done), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pat(input int k, input int p);
    return {32'h1000_0000 + 32'(k), 32'hDEAD_0000 | 32'(p),
            32'h5A5A_0000 + 32'(k * 16 + p)};
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, tile_ready, 0);
    chk({tag, "_zw"}, ena_zero_w, 0);
    chk({tag, "_zend"}, zero_end_addr, 0);
    chk({tag, "_pw"}, ena_para_w, 0);
    chk({tag, "_aw"}, ena_add_write, 0);
    chk({tag, "_addr"}, addr_para_write, 0);
    chk({tag, "_size"}, fm_size_o, 0);
    chk({tag, "_din"}, para_din, 0);
    chk({tag, "_err"}, err_sync, 0);
  endtask

  task automatic begin_layer(input int size, input int ch, input int zend);
    fm_out_size = 8'(size);
    in_channels = 10'(ch);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_strobe", ena_zero_w, 1);
    chk("zero_start", zero_start_addr, 0);
    chk("zero_end", zero_end_addr, 96'(zend));
    chk("zero_busy", busy, 1);
    chk("zero_pw", ena_para_w, 0);
    chk("zero_size", fm_size_o, 96'(size));
  endtask

  task automatic send_tile(input int k, input int p, input bit acc,
                           input bit last);
    tile_valid = 1'b1;
    tile_data = pat(k, p);
    step();
    tile_valid = 1'b0;
    tile_data = '0;
    chk("wr_en", ena_para_w, 1);
    chk("wr_add", ena_add_write, 96'(acc));
    chk("wr_addr", addr_para_write, 96'(3 * k));
    chk("wr_din", para_din, pat(k, p));
    chk("wr_zw", ena_zero_w, 0);
    if (acc) begin
      step();
      chk("add1_en", ena_para_w, 1);
      chk("add1_add", ena_add_write, 1);
      chk("add1_addr", addr_para_write, 96'(3 * k));
      chk("add1_din", para_din, pat(k, p));
    end
    step();
    if (last) begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
    end else begin
      chk("next_rdy", tile_ready, 1);
      chk("next_done", done, 0);
      chk("next_pw", ena_para_w, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fm_out_size = '0;
    in_channels = '0;
    tile_valid = 1'b0;
    tile_data = '0;
    write_ready = 1'b1;
    step();
    step();
    all_zero("reset");
    rst_n = 1'b1;
    step();

    // single overwrite pass, 5x5 -> 4 tiles
    begin_layer(5, 1, 24);
    step();
    chk("wait_rdy", tile_ready, 1);
    chk("wait_zw", ena_zero_w, 0);
    for (int k = 0; k < 4; k++) send_tile(k, 0, 1'b0, k == 3);
    step();
    chk("l1_done_once", done, 0);

    // two passes, accumulate with write_ready high
    begin_layer(5, 2, 24);
    step();
    for (int k = 0; k < 4; k++) send_tile(k, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_tile(k, 1, 1'b1, k == 3);
    step();
    chk("l2_done_once", done, 0);
    chk("l2_err", err_sync, 0);

    // two passes, write_ready low -> sticky error
    write_ready = 1'b0;
    begin_layer(5, 2, 24);
    step();
    for (int k = 0; k < 4; k++) send_tile(k, 0, 1'b0, 1'b0);
    chk("l3_err_pre", err_sync, 0);
    send_tile(0, 1, 1'b1, 1'b0);
    step();
    chk("l3_err_set", err_sync, 1);
    for (int k = 1; k < 4; k++) send_tile(k, 1, 1'b1, k == 3);
    step();
    chk("l3_err_hold", err_sync, 1);
    write_ready = 1'b1;
    rst_n = 1'b0;
    step();
    chk("l3_err_clr", err_sync, 0);
    rst_n = 1'b1;
    step();

    // tile gaps with a stray start mid-layer
    begin_layer(5, 1, 24);
    step();
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 5; g++) begin
        start = (g == 2);
        step();
        start = 1'b0;
        chk("gap_rdy", tile_ready, 1);
        chk("gap_pw", ena_para_w, 0);
        chk("gap_zw", ena_zero_w, 0);
        if (k > 0) chk("gap_addr", addr_para_write, 96'(3 * (k - 1)));
      end
      send_tile(k, 0, 1'b0, k == 3);
    end
    step();
    chk("l4_done_once", done, 0);
    chk("l4_idle", busy, 0);

    // reset asserted while in ADD0
    begin_layer(5, 2, 24);
    step();
    for (int k = 0; k < 4; k++) send_tile(k, 0, 1'b0, 1'b0);
    tile_valid = 1'b1;
    tile_data = pat(0, 1);
    step();
    tile_valid = 1'b0;
    chk("add0_add", ena_add_write, 1);
    rst_n = 1'b0;
    step();
    all_zero("rst_add0");
    rst_n = 1'b1;
    step();
    all_zero("post_rst");

    // clean layer after reset, 3x3 -> 1 tile
    begin_layer(3, 1, 6);
    step();
    send_tile(0, 0, 1'b0, 1'b1);

    // 7x7 zero range, then abort
    begin_layer(7, 1, 54);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // empty layers: no channels, then zero size
    begin_layer(5, 0, 24);
    step();
    chk("ch0_done", done, 1);
    chk("ch0_pw", ena_para_w, 0);
    chk("ch0_busy", busy, 0);
    begin_layer(0, 1, 0);
    step();
    chk("sz0_done", done, 1);
    chk("sz0_pw", ena_para_w, 0);
    step();
    chk("sz0_done_once", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
